// File: rtl/int_div_seq.sv
// int_div_seq: multi-cycle restoring divider, signed or unsigned, one quotient
// bit per cycle, with valid/ready handshakes on both sides.
module int_div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] dvd;     // dividend, then magnitude, then quotient bits
  logic [WIDTH-1:0] dsr;     // divisor, then its magnitude
  logic [WIDTH-1:0] rem;     // partial remainder
  logic             sgn;
  logic             neg_q;
  logic             neg_r;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) as an unsigned value
  assign dvd_mag = (sgn && dvd[WIDTH-1]) ? (~dvd + WIDTH'(1)) : dvd;
  assign dsr_mag = (sgn && dsr[WIDTH-1]) ? (~dsr + WIDTH'(1)) : dsr;

  // One shift-subtract step; trial[WIDTH] set means the subtract went negative
  assign shifted = {rem, dvd[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (in_valid && in_ready)     state_next = S_PREP;
      S_PREP: state_next = (dsr == '0) ? S_DONE : S_ITER;
      S_ITER: if (count == CW'(1))          state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: if (out_valid && out_ready)   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      sgn         <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      count       <= '0;
    end else begin
      in_ready  <= (state_next == S_IDLE);
      out_valid <= (state_next == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            dvd <= dividend;
            dsr <= divisor;
            sgn <= is_signed;
          end
        end
        S_PREP: begin
          neg_q <= sgn & (dvd[WIDTH-1] ^ dsr[WIDTH-1]);
          neg_r <= sgn & dvd[WIDTH-1];
          dvd   <= dvd_mag;
          dsr   <= dsr_mag;
          rem   <= '0;
          count <= CW'(WIDTH);
          if (dsr == '0) begin
            quotient    <= '1;
            remainder   <= dvd;
            div_by_zero <= 1'b1;
          end
        end
        S_ITER: begin
          rem   <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          dvd   <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
          count <= count - CW'(1);
        end
        S_FIX: begin
          quotient    <= neg_q ? (~dvd + WIDTH'(1)) : dvd;
          remainder   <= neg_r ? (~rem + WIDTH'(1)) : rem;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_div_seq.sv
// tb_int_div_seq: scoreboard bench for int_div_seq (WIDTH=32).
module tb_int_div_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int_div_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .is_signed  (is_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference behaviour from SV integer arithmetic (truncating division)
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = a; e.r = '0;
      end else begin
        e.q = W'($signed(a) / $signed(b));
        e.r = W'($signed(a) % $signed(b));
      end
      e.dz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Present a request, wait for the accept edge, push the expected result
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
    int n = 0;
    in_valid = 1'b1; dividend = a; divisor = b; is_signed = s;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_eq("accept_wait", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    sb.push_back(e);
    in_valid = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = ~s;
    check_eq("busy_after_accept", 64'(in_ready), 64'd0);
  endtask

  // Wait for a result, check it, hold it for 'stall' cycles, then take it
  task automatic collect(input int stall);
    exp_t e;
    int   lat = 0;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check_eq("latency_edges", 64'(lat), e.dz ? 64'd1 : 64'(W + 2));
    check_eq("quotient", 64'(quotient), 64'(e.q));
    check_eq("remainder", 64'(remainder), 64'(e.r));
    check_eq("div_by_zero", 64'(div_by_zero), 64'(e.dz));
    for (int k = 0; k < stall; k++) begin
      check_eq("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      check_eq("stall_out_valid", 64'(out_valid), 64'd1);
      check_eq("stall_quotient", 64'(quotient), 64'(e.q));
      check_eq("stall_remainder", 64'(remainder), 64'(e.r));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("post_hs_out_valid", 64'(out_valid), 64'd0);
    check_eq("post_hs_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;
    bit           saw_valid;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_quotient", 64'(quotient), 64'd0);
    check_eq("rst_remainder", 64'(remainder), 64'd0);
    check_eq("rst_div_by_zero", 64'(div_by_zero), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-derived expectations
    issue(32'd36, 32'd4, 1'b0, '{q: 32'd9, r: 32'd0, dz: 1'b0});
    collect(3);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, '{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dz: 1'b0});
    collect(0);
    issue(32'hFFFF_FFF9, 32'd2, 1'b0, '{q: 32'h7FFF_FFFC, r: 32'd1, dz: 1'b0});
    collect(0);
    issue(32'h24, 32'd0, 1'b0, '{q: 32'hFFFF_FFFF, r: 32'h24, dz: 1'b1});
    collect(2);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, '{q: 32'h8000_0000, r: 32'd0, dz: 1'b0});
    collect(0);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, '{q: 32'hFFFF_FFFD, r: 32'd1, dz: 1'b0});
    collect(0);
    issue(32'd3, 32'd10, 1'b0, '{q: 32'd0, r: 32'd3, dz: 1'b0});
    collect(0);

    // Back-to-back: second request held on in_valid during the first
    issue(32'd100, 32'd7, 1'b0, '{q: 32'd14, r: 32'd2, dz: 1'b0});
    in_valid = 1'b1; dividend = 32'd255; divisor = 32'd16; is_signed = 1'b0;
    collect(5);
    issue(32'd255, 32'd16, 1'b0, '{q: 32'd15, r: 32'd15, dz: 1'b0});
    collect(0);

    // Reset in the middle of an operation
    issue(32'd1000, 32'd3, 1'b0, model(32'd1000, 32'd3, 1'b0));
    void'(sb.pop_back());
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1; in_valid = 1'b1; dividend = 32'd5; divisor = 32'd1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check_eq("midrst_no_result", 64'(saw_valid), 64'd0);
    issue(32'd10, 32'd3, 1'b0, '{q: 32'd3, r: 32'd1, dz: 1'b0});
    collect(0);

    // Randomised operands against the reference model
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      issue(a, b, s, model(a, b, s));
      collect(int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
